rtc_bcd_calendar: RTL and testbench

- Free-running BCD time-of-day and calendar counter that owns the system's current date/time registers.
- Advances once per 1 Hz tick enable.
- Accepts a one-cycle parallel load of all six BCD fields from the edit stage when the user commits a change.
- Its outputs feed back into the edit stage inputs, the display mux and the alarm comparator.

---
 rtl/rtc_bcd_calendar.sv | 174 +++++++++++++++++
 tb/tb_rtc_bcd_calendar.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_calendar.sv
// -----------------------------------------------------------------------------
// rtc_bcd_calendar
//
// Free-running BCD time-of-day and calendar counter. It holds the system's
// current date and time and advances once per 1 Hz tick enable. The edit stage
// can commit a new date/time with a one-cycle parallel load of all six fields.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   tick_1hz      single-cycle enable, one per second
//   load_en       single-cycle strobe, captures the load_* fields
//   load_year     BCD year 0000-9999
//   load_month    BCD month 01-12
//   load_day      BCD day 01-31 (clamped to the month length on load)
//   load_hour     BCD hour 00-23
//   load_minute   BCD minute 00-59
//   load_second   BCD second 00-59
//   year_bcd      current year
//   month_bcd     current month
//   day_bcd       current day
//   hour_bcd      current hour
//   minute_bcd    current minute
//   second_bcd    current second
//   minute_carry  one-cycle pulse after the tick that wrapped seconds 59->00
//   day_carry     one-cycle pulse after the tick that wrapped hours 23->00
//
// Handshake: there is no backpressure. A load_en or tick_1hz that is high at a
// rising clock edge takes effect at that edge; load_en wins over tick_1hz, and
// a tick coinciding with a load is dropped along with its carry pulses.
// -----------------------------------------------------------------------------
module rtc_bcd_calendar #(
   parameter logic [15:0] RESET_YEAR = 16'h2000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick_1hz,
   input  logic        load_en,
   input  logic [15:0] load_year,
   input  logic [7:0]  load_month,
   input  logic [7:0]  load_day,
   input  logic [7:0]  load_hour,
   input  logic [7:0]  load_minute,
   input  logic [7:0]  load_second,
   output logic [15:0] year_bcd,
   output logic [7:0]  month_bcd,
   output logic [7:0]  day_bcd,
   output logic [7:0]  hour_bcd,
   output logic [7:0]  minute_bcd,
   output logic [7:0]  second_bcd,
   output logic        minute_carry,
   output logic        day_carry
);

   // Two-digit BCD increment; wrap decisions are made by the caller.
   function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // Four-digit BCD increment, 9999 wraps to 0000.
   function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[i*4 +: 4] >= 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Divisibility by 4 of a two-digit BCD number, done on the digits directly:
   // even tens need ones in {0,4,8}, odd tens need ones in {2,6}.
   function automatic logic div4(input logic [3:0] tens, input logic [3:0] ones);
      logic r;
      if (!tens[0]) r = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
      else          r = (ones == 4'd2) || (ones == 4'd6);
      return r;
   endfunction

   // Century years are leap only when the century digits are divisible by 4.
   function automatic logic is_leap(input logic [15:0] y);
      return div4(y[7:4], y[3:0]) &&
             ((y[7:0] != 8'h00) || div4(y[15:12], y[11:8]));
   endfunction

   // Month length in BCD. Invalid month codes fall back to 31 days.
   function automatic logic [7:0] days_in_month(input logic [7:0] m,
                                                input logic [15:0] y);
      logic [7:0] r;
      case (m)
         8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
         8'h02:                      r = is_leap(y) ? 8'h29 : 8'h28;
         default:                    r = 8'h31;
      endcase
      return r;
   endfunction

   logic [7:0]  dim_cur;
   logic [7:0]  dim_load;
   logic [7:0]  day_clamped;
   logic        c_min, c_hour, c_day, c_mon, c_year;
   logic [15:0] year_nxt;
   logic [7:0]  month_nxt, day_nxt, hour_nxt, minute_nxt, second_nxt;

   assign dim_cur     = days_in_month(month_bcd, year_bcd);
   assign dim_load    = days_in_month(load_month, load_year);
   assign day_clamped = (load_day > dim_load) ? dim_load : load_day;

   // Carry chain for a tick. Wraps use ">=" so an out-of-range loaded value
   // rolls over on its next increment rather than counting into bad codes.
   assign c_min  = tick_1hz && (second_bcd >= 8'h59);
   assign c_hour = c_min    && (minute_bcd >= 8'h59);
   assign c_day  = c_hour   && (hour_bcd   >= 8'h23);
   assign c_mon  = c_day    && (day_bcd    >= dim_cur);
   assign c_year = c_mon    && (month_bcd  >= 8'h12);

   always_comb begin
      year_nxt   = year_bcd;
      month_nxt  = month_bcd;
      day_nxt    = day_bcd;
      hour_nxt   = hour_bcd;
      minute_nxt = minute_bcd;
      second_nxt = second_bcd;
      if (tick_1hz) second_nxt = c_min ? 8'h00 : bcd2_inc(second_bcd);
      if (c_min)    minute_nxt = c_hour ? 8'h00 : bcd2_inc(minute_bcd);
      if (c_hour)   hour_nxt   = c_day ? 8'h00 : bcd2_inc(hour_bcd);
      if (c_day)    day_nxt    = c_mon ? 8'h01 : bcd2_inc(day_bcd);
      if (c_mon)    month_nxt  = c_year ? 8'h01 : bcd2_inc(month_bcd);
      if (c_year)   year_nxt   = bcd4_inc(year_bcd);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         year_bcd     <= RESET_YEAR;
         month_bcd    <= 8'h01;
         day_bcd      <= 8'h01;
         hour_bcd     <= 8'h00;
         minute_bcd   <= 8'h00;
         second_bcd   <= 8'h00;
         minute_carry <= 1'b0;
         day_carry    <= 1'b0;
      end else begin
         minute_carry <= !load_en && c_min;
         day_carry    <= !load_en && c_day;
         if (load_en) begin
            year_bcd   <= load_year;
            month_bcd  <= load_month;
            day_bcd    <= day_clamped;
            hour_bcd   <= load_hour;
            minute_bcd <= load_minute;
            second_bcd <= load_second;
         end else if (tick_1hz) begin
            year_bcd   <= year_nxt;
            month_bcd  <= month_nxt;
            day_bcd    <= day_nxt;
            hour_bcd   <= hour_nxt;
            minute_bcd <= minute_nxt;
            second_bcd <= second_nxt;
         end
      end
   end

endmodule

// File: tb/tb_rtc_bcd_calendar.sv
// -----------------------------------------------------------------------------
// tb_rtc_bcd_calendar
//
// Directed bench for rtc_bcd_calendar. The driver applies loads, ticks and
// resets and pushes the hand-computed expected state into exp_q; the monitor
// pops one entry at each falling edge where the queue is non-empty and
// compares it against the DUT outputs.
// Expected state packing: {year, month, day, hour, minute, second,
// minute_carry, day_carry}.
// -----------------------------------------------------------------------------
module tb_rtc_bcd_calendar;

   localparam int W = 58;

   logic        clk;
   logic        rst_n;
   logic        tick_1hz;
   logic        load_en;
   logic [15:0] load_year;
   logic [7:0]  load_month, load_day, load_hour, load_minute, load_second;
   logic [15:0] year_bcd;
   logic [7:0]  month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd;
   logic        minute_carry, day_carry;

   logic [W-1:0] exp_q[$];
   int           tests_run = 0;
   int           tests_failed = 0;
   logic         stim_done = 1'b0;

   rtc_bcd_calendar #(.RESET_YEAR(16'h2000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_1hz     (tick_1hz),
      .load_en      (load_en),
      .load_year    (load_year),
      .load_month   (load_month),
      .load_day     (load_day),
      .load_hour    (load_hour),
      .load_minute  (load_minute),
      .load_second  (load_second),
      .year_bcd     (year_bcd),
      .month_bcd    (month_bcd),
      .day_bcd      (day_bcd),
      .hour_bcd     (hour_bcd),
      .minute_bcd   (minute_bcd),
      .second_bcd   (second_bcd),
      .minute_carry (minute_carry),
      .day_carry    (day_carry)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL timeout: stimulus did not complete");
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   // Inputs change at posedge+1; step() lets exactly one rising edge sample them.
   task automatic step();
      @(posedge clk);
      #1;
      load_en  = 1'b0;
      tick_1hz = 1'b0;
   endtask

   task automatic expect_state(input logic [15:0] y, input logic [7:0] mo,
                               input logic [7:0] d, input logic [7:0] h,
                               input logic [7:0] mi, input logic [7:0] s,
                               input logic mc, input logic dc);
      exp_q.push_back({y, mo, d, h, mi, s, mc, dc});
   endtask

   task automatic do_load(input logic [15:0] y, input logic [7:0] mo,
                          input logic [7:0] d, input logic [7:0] h,
                          input logic [7:0] mi, input logic [7:0] s,
                          input logic with_tick);
      load_year   = y;
      load_month  = mo;
      load_day    = d;
      load_hour   = h;
      load_minute = mi;
      load_second = s;
      load_en     = 1'b1;
      tick_1hz    = with_tick;
      step();
   endtask

   task automatic do_tick();
      tick_1hz = 1'b1;
      step();
   endtask

   task automatic do_idle();
      step();
   endtask

   // Wait until the monitor has consumed everything issued so far.
   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; tick_1hz = 1'b0; load_en = 1'b0;
      load_year = 16'h0; load_month = 8'h0; load_day = 8'h0;
      load_hour = 8'h0; load_minute = 8'h0; load_second = 8'h0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // reset state, then hold with no stimulus
      expect_state(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      do_idle();
      expect_state(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      drain();

      // three ticks
      do_tick(); expect_state(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0); drain();
      do_tick(); expect_state(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0); drain();
      do_tick(); expect_state(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0); drain();

      // seconds ones-digit carry 09 -> 10
      do_load(16'h2023, 8'h05, 8'h10, 8'h10, 8'h20, 8'h09, 1'b0);
      do_tick(); expect_state(16'h2023, 8'h05, 8'h10, 8'h10, 8'h20, 8'h10, 1'b0, 1'b0); drain();

      // minute carry only
      do_load(16'h2023, 8'h05, 8'h10, 8'h10, 8'h20, 8'h59, 1'b0);
      do_tick(); expect_state(16'h2023, 8'h05, 8'h10, 8'h10, 8'h21, 8'h00, 1'b1, 1'b0); drain();
      do_idle(); expect_state(16'h2023, 8'h05, 8'h10, 8'h10, 8'h21, 8'h00, 1'b0, 1'b0); drain();

      // year rollover with both carries for one cycle
      do_load(16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 1'b0);
      expect_state(16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0); drain();
      do_tick(); expect_state(16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1); drain();
      do_idle(); expect_state(16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); drain();

      // leap years
      do_load(16'h2024, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 1'b0);
      do_tick(); expect_state(16'h2024, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1); drain();
      do_load(16'h2024, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59, 1'b0);
      do_tick(); expect_state(16'h2024, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1); drain();
      do_load(16'h1900, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 1'b0);
      do_tick(); expect_state(16'h1900, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1); drain();
      do_load(16'h2000, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 1'b0);
      do_tick(); expect_state(16'h2000, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1); drain();

      // day clamp on load
      do_load(16'h2023, 8'h04, 8'h31, 8'h12, 8'h00, 8'h00, 1'b0);
      expect_state(16'h2023, 8'h04, 8'h30, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0); drain();
      do_load(16'h2023, 8'h02, 8'h30, 8'h12, 8'h00, 8'h00, 1'b0);
      expect_state(16'h2023, 8'h02, 8'h28, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0); drain();
      do_load(16'h2024, 8'h02, 8'h31, 8'h12, 8'h00, 8'h00, 1'b0);
      expect_state(16'h2024, 8'h02, 8'h29, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0); drain();

      // 9999 wraps to 0000
      do_load(16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 1'b0);
      do_tick(); expect_state(16'h0000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1); drain();

      // load wins over a coincident tick
      do_load(16'h2030, 8'h06, 8'h15, 8'h10, 8'h20, 8'h30, 1'b1);
      expect_state(16'h2030, 8'h06, 8'h15, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0); drain();
      do_tick(); expect_state(16'h2030, 8'h06, 8'h15, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0); drain();

      // async reset between ticks
      do_load(16'h2050, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 1'b0);
      expect_state(16'h2050, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 1'b0, 1'b0); drain();
      rst_n = 1'b0;
      #1;
      expect_state(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); drain();
      #2 rst_n = 1'b1;
      do_idle(); expect_state(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); drain();

      stim_done = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd,
                     second_bcd, minute_carry, day_carry};
            tests_run++;
            if (act_v !== exp_v) begin
               tests_failed++;
               $display("[TB] FAIL state #%0d: got %h-%h-%h %h:%h:%h mc=%b dc=%b, expected %h-%h-%h %h:%h:%h mc=%b dc=%b",
                        tests_run,
                        act_v[57:42], act_v[41:34], act_v[33:26], act_v[25:18],
                        act_v[17:10], act_v[9:2], act_v[1], act_v[0],
                        exp_v[57:42], exp_v[41:34], exp_v[33:26], exp_v[25:18],
                        exp_v[17:10], exp_v[9:2], exp_v[1], exp_v[0]);
            end
         end
         if (stim_done) begin
            if (exp_q.size() != 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL drain: %0d expected entries left, required 0", exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
            $finish;
         end
      end
   end

endmodule
